// File: rtl/data_switch_pkg.sv
// Shared types and window geometry for the data_switch producer (data_switch_driver).
package data_switch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  // A window is one beat plus the first PAD_WORDS words of the following beat.
  localparam int PAD_WORDS = 2;
  localparam int IN_SIZE   = 8 + PAD_WORDS;

  function automatic int in_size(input int conv_units);
    return conv_units + PAD_WORDS;
  endfunction

endpackage

// File: rtl/data_switch_driver.sv
// Producer side of data_switch: builds CONV_UNITS+2 word windows and sweeps sel per window.
// Optional build macro EDGE_REPLICATE_EN: pad words replicate the last beat word instead of zero.
module data_switch_driver
  import data_switch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_UNITS = 8,
  parameter int KERNEL_W   = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DATA_WIDTH*CONV_UNITS-1:0]             s_data,
  input  logic                                         s_valid,
  input  logic                                         s_last,
  output logic                                         s_ready,
  output logic [DATA_WIDTH*(CONV_UNITS+PAD_WORDS)-1:0] x_in,
  output logic [1:0]                                   sel,
  output logic                                         m_valid,
  output logic                                         m_last,
  input  logic                                         m_ready
);

  localparam int WIN_WORDS = in_size(CONV_UNITS);
  localparam int BEAT_W    = DATA_WIDTH * CONV_UNITS;
  localparam int WIN_W     = DATA_WIDTH * WIN_WORDS;
  localparam logic [1:0] SEL_MAX = 2'(KERNEL_W - 1);

  function automatic logic [WIN_W-1:0] pad_window(input logic [BEAT_W-1:0] beat);
    logic [DATA_WIDTH-1:0] pad;
`ifdef EDGE_REPLICATE_EN
    pad = beat[BEAT_W-1 -: DATA_WIDTH];
`else
    pad = '0;
`endif
    return {pad, pad, beat};
  endfunction

  state_t              state;
  logic [BEAT_W-1:0]   cur;
  logic [BEAT_W-1:0]   nxt;
  logic                nxt_last;
  logic                padded;

  logic s_fire;
  logic m_fire;
  logic sweep_end;
  logic sweep_adv;

  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign sweep_end = (state == SWEEP) && m_fire && (sel == SEL_MAX);
  // End of a non-padded window: the lookahead beat becomes the current beat.
  assign sweep_adv = sweep_end && !padded;

  // Beat buffers carry no reset; stale contents are never used after IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && s_fire) begin
      cur <= s_data;
    end else if (sweep_adv) begin
      cur <= nxt;
    end
    if (state == WAIT && s_fire) begin
      nxt <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_in     <= '0;
      sel      <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      s_ready  <= 1'b0;
      padded   <= 1'b0;
      nxt_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          if (s_fire) begin
            if (s_last) begin
              x_in    <= pad_window(s_data);
              sel     <= '0;
              padded  <= 1'b1;
              m_valid <= 1'b1;
              m_last  <= (SEL_MAX == 2'd0);
              s_ready <= 1'b0;
              state   <= SWEEP;
            end else begin
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          if (s_fire) begin
            nxt_last <= s_last;
            x_in     <= {s_data[2*DATA_WIDTH-1:0], cur};
            sel      <= '0;
            padded   <= 1'b0;
            m_valid  <= 1'b1;
            s_ready  <= 1'b0;
            state    <= SWEEP;
          end
        end
        SWEEP: begin
          if (m_fire) begin
            if (sel < SEL_MAX) begin
              sel    <= sel + 2'd1;
              m_last <= padded && ((sel + 2'd1) == SEL_MAX);
            end else if (padded) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              padded  <= 1'b0;
              s_ready <= 1'b1;
              state   <= IDLE;
            end else if (nxt_last) begin
              x_in   <= pad_window(nxt);
              sel    <= '0;
              padded <= 1'b1;
              m_last <= (SEL_MAX == 2'd0);
            end else begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
              state   <= WAIT;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_switch_driver.sv
// Bench for data_switch_driver: KERNEL_W=3 and KERNEL_W=1 instances sharing one input stream.
module tb_data_switch_driver;

  localparam int DW = 16;
  localparam int CU = 8;
  localparam int BW = DW * CU;
  localparam int WW = DW * (CU + 2);

  typedef logic [BW-1:0] beat_t;
  typedef struct packed {
    logic [WW-1:0] x;
    logic [1:0]    sel;
    logic          last;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst_a, rst_b;
  logic [BW-1:0] s_data;
  logic          s_valid, s_last, m_ready;
  logic          a_s_ready, a_m_valid, a_m_last;
  logic [WW-1:0] a_x_in;
  logic [1:0]    a_sel;
  logic          b_s_ready, b_m_valid, b_m_last;
  logic [WW-1:0] b_x_in;
  logic [1:0]    b_sel;

  always #5 clk = ~clk;

  data_switch_driver #(.DATA_WIDTH(DW), .CONV_UNITS(CU), .KERNEL_W(3)) dut (
    .clk(clk), .rst(rst_a), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(a_s_ready), .x_in(a_x_in), .sel(a_sel), .m_valid(a_m_valid),
    .m_last(a_m_last), .m_ready(m_ready));

  data_switch_driver #(.DATA_WIDTH(DW), .CONV_UNITS(CU), .KERNEL_W(1)) dut_k1 (
    .clk(clk), .rst(rst_b), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(b_s_ready), .x_in(b_x_in), .sel(b_sel), .m_valid(b_m_valid),
    .m_last(b_m_last), .m_ready(m_ready));

  xfer_t got[$];
  xfer_t exp_q[$];
  xfer_t ref_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    use_b = 1'b0;

  always @(posedge clk) begin
    if (!rst_a && a_m_valid && m_ready) got.push_back(xfer_t'({a_x_in, a_sel, a_m_last}));
    if (!rst_b && b_m_valid && m_ready) got.push_back(xfer_t'({b_x_in, b_sel, b_m_last}));
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] pad_of(input beat_t b);
`ifdef EDGE_REPLICATE_EN
    return b[BW-1 -: DW];
`else
    return '0;
`endif
  endfunction

  function automatic xfer_t getx(input int i);
    xfer_t z;
    z = '0;
    if (i < got.size()) z = got[i];
    return z;
  endfunction

  // Reference: every beat yields one window, each window yields kw transfers.
  task automatic build_ref(input beat_t r[$], input int kw);
    logic [WW-1:0] w;
    bit            lastb;
    exp_q.delete();
    for (int i = 0; i < r.size(); i++) begin
      lastb = (i == r.size() - 1);
      if (lastb) w = {pad_of(r[i]), pad_of(r[i]), r[i]};
      else       w = {r[i+1][2*DW-1:0], r[i]};
      for (int s = 0; s < kw; s++)
        exp_q.push_back(xfer_t'({w, 2'(s), 1'(lastb && (s == kw - 1))}));
    end
  endtask

  task automatic send_beat(input beat_t b, input bit last, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = b;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    while (!(use_b ? b_s_ready : a_s_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_timeout", 192'(n >= 200), 192'(0));
    if (n < 200) @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_and_compare(input string tag);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 1000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, 192'(got.size()), 192'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), 192'(got[i]), 192'(exp_q[i]));
  endtask

  task automatic run_row(input beat_t r[$], input int gap_max, input int kw, input string tag);
    got.delete();
    build_ref(r, kw);
    for (int i = 0; i < r.size(); i++)
      send_beat(r[i], (i == r.size() - 1), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    wait_and_compare(tag);
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int w = 0; w < BW / 32; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    beat_t         row[$];
    beat_t         a, b;
    logic [WW-1:0] xhold;
    logic [DW-1:0] pv;
    int            len;

    rst_a = 1'b1; rst_b = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 192'(a_m_valid), 192'(0));
    chk("rst_s_ready", 192'(a_s_ready), 192'(0));
    chk("rst_sel", 192'(a_sel), 192'(0));
    chk("rst_x_in", 192'(a_x_in), 192'(0));
    chk("rst_m_last", 192'(a_m_last), 192'(0));
    chk("rst_k1_m_valid", 192'(b_m_valid), 192'(0));
    rst_a = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 192'(a_s_ready), 192'(1));
    chk("idle_m_valid", 192'(a_m_valid), 192'(0));

    // Two-beat row with known words
    for (int i = 0; i < CU; i++) begin
      a[DW*i +: DW] = DW'(i + 1);
      b[DW*i +: DW] = DW'(i + 9);
    end
    row = '{a, b};
    run_row(row, 0, 3, "two_beat");
    chk("two_beat_win0", 192'(getx(0).x), 192'({16'd10, 16'd9, a}));
`ifdef EDGE_REPLICATE_EN
    pv = 16'd16;
`else
    pv = 16'd0;
`endif
    chk("two_beat_pad", 192'(getx(3).x[WW-1 -: 2*DW]), 192'({pv, pv}));
    chk("two_beat_sels", 192'({getx(0).sel, getx(1).sel, getx(2).sel, getx(3).sel, getx(4).sel, getx(5).sel}),
        192'(12'b00_01_10_00_01_10));
    chk("two_beat_lasts", 192'({getx(0).last, getx(1).last, getx(2).last, getx(3).last, getx(4).last, getx(5).last}),
        192'(6'b000001));

    // Backpressure at sel=1
    row = '{rand_beat(), rand_beat()};
    got.delete();
    build_ref(row, 3);
    m_ready = 1'b0;
    send_beat(row[0], 1'b0, 0);
    send_beat(row[1], 1'b1, 0);
    chk("bp_m_valid", 192'(a_m_valid), 192'(1));
    chk("bp_sel0", 192'(a_sel), 192'(0));
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    xhold = a_x_in;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_sel_hold%0d", k), 192'(a_sel), 192'(1));
      chk($sformatf("bp_x_hold%0d", k), 192'(a_x_in), 192'(xhold));
      chk($sformatf("bp_s_ready%0d", k), 192'(a_s_ready), 192'(0));
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_and_compare("bp");

    // Reset held for 3 cycles in the middle of a sweep
    row = '{rand_beat(), rand_beat()};
    got.delete();
    m_ready = 1'b0;
    send_beat(row[0], 1'b0, 0);
    send_beat(row[1], 1'b0, 0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_hold_m_valid", 192'(a_m_valid), 192'(0));
    chk("midrst_hold_s_ready", 192'(a_s_ready), 192'(0));
    rst_a = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", 192'(a_m_valid), 192'(0));
    chk("midrst_sel", 192'(a_sel), 192'(0));
    chk("midrst_x_in", 192'(a_x_in), 192'(0));
    chk("midrst_m_last", 192'(a_m_last), 192'(0));
    chk("midrst_idle_ready", 192'(a_s_ready), 192'(1));
    m_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_more_xfers", 192'(got.size()), 192'(1));

    // Single-beat row
    a = {16'h4900, 16'h4700, 16'h4500, 16'h4300, 16'h4100, 16'h3F00, 16'h3E00, 16'h3C00};
    row = '{a};
    run_row(row, 0, 3, "single");
`ifdef EDGE_REPLICATE_EN
    pv = 16'h4900;
`else
    pv = 16'h0000;
`endif
    chk("single_pad", 192'(getx(0).x[WW-1 -: 2*DW]), 192'({pv, pv}));
    chk("single_lasts", 192'({getx(0).last, getx(1).last, getx(2).last}), 192'(3'b001));

    // Random rows: gapless reference run, then the same rows with s_valid gaps
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(1, 4));
      row.delete();
      for (int i = 0; i < len; i++) row.push_back(rand_beat());
      run_row(row, 0, 3, $sformatf("gapless%0d", r));
      ref_q = got;
      run_row(row, 3, 3, $sformatf("gaps%0d", r));
      chk($sformatf("gaps_vs_gapless_count%0d", r), 192'(got.size()), 192'(ref_q.size()));
      for (int i = 0; i < ref_q.size() && i < got.size(); i++)
        chk($sformatf("gaps_vs_gapless%0d_%0d", r, i), 192'(got[i]), 192'(ref_q[i]));
    end

    // KERNEL_W=1 instance, 3-beat row
    rst_a = 1'b1;
    rst_b = 1'b0;
    use_b = 1'b1;
    repeat (2) @(negedge clk);
    row = '{rand_beat(), rand_beat(), rand_beat()};
    run_row(row, 1, 1, "kw1");
    chk("kw1_sels", 192'({getx(0).sel, getx(1).sel, getx(2).sel}), 192'(0));
    chk("kw1_lasts", 192'({getx(0).last, getx(1).last, getx(2).last}), 192'(3'b001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
